// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side pointer and status controller for the async FIFO
// Consumes the synchronized Gray write pointer; all state lives in the read clock domain.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wq2_wptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_valid,
  output logic                  underflow
);

  localparam int              PW       = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   AE_LEVEL = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic          accept;

  assign accept     = rd_en & ~empty;
  assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, accept};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign level_next = wbin - rbin_next;
  assign rd_addr    = rbin[ADDR_WIDTH-1:0];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(wq2_wptr >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbin         <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr         <= rgray_next;
      // Compared against the post-read pointer so the last read flags empty on its own edge.
      empty        <= (rgray_next == wq2_wptr);
      almost_empty <= (level_next <= AE_LEVEL);
      rd_level     <= level_next;
      rd_valid     <= accept;
      underflow    <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [3:0] wq2_wptr;
  logic [2:0] rd_addr;
  logic [3:0] rptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       rd_valid;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AE_THRESH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wq2_wptr     (wq2_wptr),
    .rd_addr      (rd_addr),
    .rptr         (rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .rd_valid     (rd_valid),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rptr"},  32'(rptr),         32'h0);
    check_eq({tag, "_raddr"}, 32'(rd_addr),      32'h0);
    check_eq({tag, "_empty"}, 32'(empty),        32'h1);
    check_eq({tag, "_ae"},    32'(almost_empty), 32'h1);
    check_eq({tag, "_level"}, 32'(rd_level),     32'h0);
    check_eq({tag, "_valid"}, 32'(rd_valid),     32'h0);
    check_eq({tag, "_uflow"}, 32'(underflow),    32'h0);
  endtask

  // Expected values for the drain sequence after each of the three read edges.
  logic [3:0] exp_rptr  [3] = '{4'b0001, 4'b0011, 4'b0010};
  logic [3:0] exp_level [3] = '{4'd2, 4'd1, 4'd0};
  logic       exp_ae    [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    logic [3:0] prev_rptr;

    // 1. Reset overrides rd_en and a non-zero write pointer.
    rst = 1'b1; rd_en = 1'b1; wq2_wptr = 4'b0011;
    step();
    check_reset_state("reset");
    rst = 1'b0; rd_en = 1'b0; wq2_wptr = 4'b0000;
    step();
    check_eq("idle_empty", 32'(empty), 32'h1);

    // 2. Fill to 3 then drain.
    wq2_wptr = 4'b0010;
    step();
    check_eq("fill_empty", 32'(empty),        32'h0);
    check_eq("fill_level", 32'(rd_level),     32'd3);
    check_eq("fill_ae",    32'(almost_empty), 32'h0);
    check_eq("fill_raddr", 32'(rd_addr),      32'd0);
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("drain%0d_raddr", k), 32'(rd_addr),      32'(k + 1));
      check_eq($sformatf("drain%0d_rptr", k),  32'(rptr),         32'(exp_rptr[k]));
      check_eq($sformatf("drain%0d_level", k), 32'(rd_level),     32'(exp_level[k]));
      check_eq($sformatf("drain%0d_ae", k),    32'(almost_empty), 32'(exp_ae[k]));
      check_eq($sformatf("drain%0d_valid", k), 32'(rd_valid),     32'h1);
    end
    check_eq("drain_empty", 32'(empty), 32'h1);
    rd_en = 1'b0;
    step();
    check_eq("drain_valid_off", 32'(rd_valid), 32'h0);

    // 3. Underflow: rejected read, sticky flag.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("uf_rptr",  32'(rptr),      32'b0010);
    check_eq("uf_raddr", 32'(rd_addr),   32'd3);
    check_eq("uf_valid", 32'(rd_valid),  32'h0);
    check_eq("uf_flag",  32'(underflow), 32'h1);
    step(); step();
    check_eq("uf_sticky", 32'(underflow), 32'h1);
    check_eq("uf_rptr2",  32'(rptr),      32'b0010);

    // 4. Full level from rbin=0.
    rst = 1'b1; wq2_wptr = 4'b0000;
    step();
    check_eq("rst2_uflow", 32'(underflow), 32'h0);
    rst = 1'b0; wq2_wptr = 4'b1100;
    step();
    check_eq("full_level", 32'(rd_level),     32'b1000);
    check_eq("full_empty", 32'(empty),        32'h0);
    check_eq("full_ae",    32'(almost_empty), 32'h0);

    // 5. Wrap-around: one write and one read per cycle, level stays at 8.
    rd_en = 1'b1;
    prev_rptr = rptr;
    for (int k = 0; k < 20; k++) begin
      wq2_wptr = gray(9 + k);
      step();
      check_eq($sformatf("wrap%0d_rptr", k),  32'(rptr),    32'(gray(k + 1)));
      check_eq($sformatf("wrap%0d_raddr", k), 32'(rd_addr), 32'((k + 1) % 8));
      check_eq($sformatf("wrap%0d_onebit", k), 32'($countones(rptr ^ prev_rptr)), 32'd1);
      check_eq($sformatf("wrap%0d_level", k), 32'(rd_level), 32'd8);
      if (k == 15) begin
        check_eq("wrap_prev_1000", 32'(prev_rptr), 32'b1000);
        check_eq("wrap_to_0000",   32'(rptr),      32'b0000);
      end
      prev_rptr = rptr;
    end
    check_eq("wrap_uflow", 32'(underflow), 32'h0);

    // 6. Reset mid-stream: drain from 8 to 5, then reset with rd_en held.
    for (int k = 0; k < 3; k++) step();
    check_eq("mid_level", 32'(rd_level), 32'd5);
    rst = 1'b1;
    step();
    check_reset_state("midrst");
    rst = 1'b0; rd_en = 1'b0; wq2_wptr = 4'b0000;
    step();
    check_eq("post_rptr",  32'(rptr),  32'h0);
    check_eq("post_empty", 32'(empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
